// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - single-port frame buffer arbiter: VGA reads first, buffered writes fill idle cycles.
// Define FRAME_BUFFER_ARBITER_STARVE_GUARD_EN to force a buffered write after MaxWait starved cycles.
module frame_buffer_arbiter #(
  parameter int HAddrSize = 11,
  parameter int VAddrSize = 11,
  parameter int FifoDepth = 4,
  parameter int MaxWait   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         vga_rd_req,
  input  logic [HAddrSize-1:0]         vga_addr_h,
  input  logic [VAddrSize-1:0]         vga_addr_v,
  output logic [2:0]                   vga_color,
  output logic                         vga_color_valid,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [HAddrSize-1:0]         wr_addr_h,
  input  logic [VAddrSize-1:0]         wr_addr_v,
  input  logic [2:0]                   wr_color,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [HAddrSize-1:0]         mem_addr_h,
  output logic [VAddrSize-1:0]         mem_addr_v,
  output logic [2:0]                   mem_wdata,
  input  logic [2:0]                   mem_rdata,
  output logic [$clog2(FifoDepth):0]   fifo_count,
  output logic [7:0]                   stall_count
);

  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FifoDepth);

  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || MaxWait < 1) begin : g_param_check
    $error("frame_buffer_arbiter: FifoDepth must be a power of 2 >= 2 and MaxWait >= 1");
  end

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

  grant_e grant;
  logic   forced;
  logic   push, pop;

  logic [HAddrSize-1:0] buf_h_q [FifoDepth];
  logic [VAddrSize-1:0] buf_v_q [FifoDepth];
  logic [2:0]           buf_c_q [FifoDepth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ready_q, wr_ready_d;
  logic          rd_pend_q, rd_pend_d;
  logic [2:0]    vga_color_q, vga_color_d;
  logic          vga_valid_q, vga_valid_d;

`ifdef FRAME_BUFFER_ARBITER_STARVE_GUARD_EN
  localparam int WW = $clog2(MaxWait + 1);
  localparam logic [WW-1:0] MaxWaitC = WW'(MaxWait);
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    stall_q, stall_d;

  assign forced = (count_q != '0) && (wait_q >= MaxWaitC);

  always_comb begin
    wait_d  = wait_q;
    stall_d = stall_q;
    if (pop || count_q == '0) begin
      wait_d = '0;
    end else if (wait_q != MaxWaitC) begin
      wait_d = wait_q + 1'b1;
    end
    // The read that loses to a forced write is dropped, not retried.
    if (forced && vga_rd_req && stall_q != 8'hFF) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign forced      = 1'b0;
  assign stall_count = 8'd0;
`endif

  // Grant uses registered FIFO state only, so a fresh push is never written in its own cycle.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (forced) begin
      grant = GNT_WRITE;
    end else if (vga_rd_req) begin
      grant = GNT_READ;
    end else if (count_q != '0) begin
      grant = GNT_WRITE;
    end
  end

  assign push = wr_valid && wr_ready_q;
  assign pop  = (grant == GNT_WRITE);

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr_h = '0;
    mem_addr_v = '0;
    mem_wdata  = 3'b000;
    case (grant)
      GNT_READ: begin
        mem_en     = 1'b1;
        mem_addr_h = vga_addr_h;
        mem_addr_v = vga_addr_v;
      end
      GNT_WRITE: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr_h = buf_h_q[rd_ptr_q];
        mem_addr_v = buf_v_q[rd_ptr_q];
        mem_wdata  = buf_c_q[rd_ptr_q];
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wr_ready_d  = (count_d < DepthC);
    rd_pend_d   = (grant == GNT_READ);
    vga_valid_d = rd_pend_q;
    vga_color_d = rd_pend_q ? mem_rdata : vga_color_q;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_h_q[wr_ptr_q] <= wr_addr_h;
      buf_v_q[wr_ptr_q] <= wr_addr_v;
      buf_c_q[wr_ptr_q] <= wr_color;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ready_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      vga_color_q <= 3'b000;
      vga_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ready_q  <= wr_ready_d;
      rd_pend_q   <= rd_pend_d;
      vga_color_q <= vga_color_d;
      vga_valid_q <= vga_valid_d;
    end
  end

  assign wr_ready        = wr_ready_q;
  assign fifo_count      = count_q;
  assign vga_color       = vga_color_q;
  assign vga_color_valid = vga_valid_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - directed self-checking bench for frame_buffer_arbiter.
module tb_frame_buffer_arbiter;

`ifdef FRAME_BUFFER_ARBITER_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        vga_rd_req;
  logic [10:0] vga_addr_h, vga_addr_v;
  logic [2:0]  vga_color;
  logic        vga_color_valid;
  logic        wr_valid, wr_ready;
  logic [10:0] wr_addr_h, wr_addr_v;
  logic [2:0]  wr_color;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr_h, mem_addr_v;
  logic [2:0]  mem_wdata, mem_rdata;
  logic [2:0]  fifo_count;
  logic [7:0]  stall_count;

  int n_checks = 0;
  int n_errors = 0;

  frame_buffer_arbiter dut (
    .clock(clock), .reset(reset),
    .vga_rd_req(vga_rd_req), .vga_addr_h(vga_addr_h), .vga_addr_v(vga_addr_v),
    .vga_color(vga_color), .vga_color_valid(vga_color_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr_h(wr_addr_h), .wr_addr_v(wr_addr_v), .wr_color(wr_color),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr_h(mem_addr_h), .mem_addr_v(mem_addr_v),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_count(fifo_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; vga_rd_req = 1'b1; vga_addr_h = '0; vga_addr_v = '0;
    wr_valid = 1'b1; wr_addr_h = '0; wr_addr_v = '0; wr_color = '0; mem_rdata = '0;

    // reset held with traffic offered
    repeat (2) @(posedge clock);
    #4;
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_color", vga_color, 0);
    check_eq("rst_valid", vga_color_valid, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_stall", stall_count, 0);
    tick();
    vga_rd_req = 1'b0; wr_valid = 1'b0; reset = 1'b1;
    #3 check_eq("release_cycle_ready", wr_ready, 0);
    tick();
    #3 check_eq("ready_after_release", wr_ready, 1);
    check_eq("idle_mem_en", mem_en, 0);

    // single read, latency 2
    tick();
    vga_rd_req = 1'b1; vga_addr_h = 11'd2; vga_addr_v = 11'd3;
    #3 check_eq("rd_en", mem_en, 1);
    check_eq("rd_we", mem_we, 0);
    check_eq("rd_addr_h", mem_addr_h, 2);
    check_eq("rd_addr_v", mem_addr_v, 3);
    tick();
    vga_rd_req = 1'b0; mem_rdata = 3'b101;
    #3 check_eq("rd_n1_valid", vga_color_valid, 0);
    check_eq("rd_n1_en", mem_en, 0);
    tick();
    mem_rdata = 3'b000;
    #3 check_eq("rd_n2_color", vga_color, 3'b101);
    check_eq("rd_n2_valid", vga_color_valid, 1);
    tick();
    #3 check_eq("rd_n3_valid", vga_color_valid, 0);
    check_eq("rd_n3_hold", vga_color, 3'b101);

    // five pushes against a busy reader: four fit
    tick();
    vga_rd_req = 1'b1; vga_addr_h = '0; vga_addr_v = '0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr_h = 11'(10 + i); wr_addr_v = 11'(20 + i); wr_color = 3'(i + 1);
      #3 check_eq("fill_ready", wr_ready, (i < 4) ? 1 : 0);
      check_eq("fill_no_write", mem_we, 0);
      tick();
    end
    wr_valid = 1'b0;
    #3 check_eq("fill_count", fifo_count, 4);
    check_eq("fill_ready_low", wr_ready, 0);
    tick();
    vga_rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3 check_eq("drain_we", mem_we, 1);
      check_eq("drain_h", mem_addr_h, 10 + i);
      check_eq("drain_v", mem_addr_v, 20 + i);
      check_eq("drain_data", mem_wdata, i + 1);
      tick();
    end
    #3 check_eq("drain_idle", mem_en, 0);
    check_eq("drain_count", fifo_count, 0);

    // full FIFO: same-cycle pop does not admit a push
    tick();
    vga_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr_h = 11'(30 + i); wr_addr_v = 11'(i); wr_color = 3'(i + 4);
      tick();
    end
    vga_rd_req = 1'b0; wr_addr_h = 11'd99; wr_color = 3'b010;
    #3 check_eq("full_ready", wr_ready, 0);
    check_eq("full_pop_addr", mem_addr_h, 30);
    check_eq("full_count", fifo_count, 4);
    tick();
    #3 check_eq("after_refuse_count", fifo_count, 3);
    check_eq("after_refuse_ready", wr_ready, 1);
    check_eq("pop1_addr", mem_addr_h, 31);
    tick();
    wr_valid = 1'b0;
    #3 check_eq("push_pop_count", fifo_count, 3);
    check_eq("pop2_addr", mem_addr_h, 32);
    tick();
    #3 check_eq("pop3_addr", mem_addr_h, 33);
    tick();
    #3 check_eq("pop4_addr", mem_addr_h, 99);
    check_eq("pop4_data", mem_wdata, 3'b010);
    tick();
    #3 check_eq("full_drain_idle", mem_en, 0);
    check_eq("full_drain_count", fifo_count, 0);

    // one buffered write vs. a reader that never lets go
    tick();
    vga_rd_req = 1'b1; mem_rdata = 3'b111;
    wr_valid = 1'b1; wr_addr_h = 11'd7; wr_addr_v = 11'd8; wr_color = 3'b011;
    tick();
    wr_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #3 check_eq("starve_we", mem_we, (Guard && c == 17) ? 1 : 0);
      if (c >= 2) check_eq("starve_valid", vga_color_valid, (Guard && c == 19) ? 0 : 1);
      tick();
    end
    check_eq("starve_stall", stall_count, Guard ? 1 : 0);
    check_eq("starve_color", vga_color, 3'b111);
    vga_rd_req = 1'b0;
    #3 check_eq("starve_late_we", mem_we, Guard ? 0 : 1);
    check_eq("starve_late_addr", mem_addr_h, Guard ? 0 : 7);
    tick();
    #3 check_eq("starve_end_count", fifo_count, 0);

    // reset mid-operation
    tick();
    vga_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr_h = 11'(40 + i);
      tick();
    end
    wr_valid = 1'b0;
    #3 check_eq("pre_rst_count", fifo_count, 3);
    tick();
    reset = 1'b0;
    #3 check_eq("mid_rst_count", fifo_count, 0);
    check_eq("mid_rst_valid", vga_color_valid, 0);
    check_eq("mid_rst_en", mem_en, 0);
    tick();
    vga_rd_req = 1'b0;
    #3 check_eq("mid_rst_valid2", vga_color_valid, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3 check_eq("post_rst_en", mem_en, 0);
      check_eq("post_rst_valid", vga_color_valid, 0);
      tick();
    end
    check_eq("post_rst_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- HAddrSize, 11, horizontal address width.
- VAddrSize, 11, vertical address width.
- FifoDepth, 4, write-buffer entries (power of 2, >=2).
- MaxWait, 16, starvation threshold in cycles (guard build only).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all logic on rising edge.
- reset, in, 1, asynchronous active-low reset.
- vga_rd_req, in, 1, scan-out pixel read request.
- vga_addr_h, in, HAddrSize, read column.
- vga_addr_v, in, VAddrSize, read row.
- vga_color, out, 3, registered {r,g,b} read result.
- vga_color_valid, out, 1, one-cycle pulse when vga_color is updated.
- wr_valid, in, 1, writer offers a pixel.
- wr_ready, out, 1, buffer can accept a pixel.
- wr_addr_h, in, HAddrSize, write column.
- wr_addr_v, in, VAddrSize, write row.
- wr_color, in, 3, write {r,g,b}.
- mem_en, out, 1, memory access this cycle.
- mem_we, out, 1, 1 = write, 0 = read.
- mem_addr_h, out, HAddrSize, memory column.
- mem_addr_v, out, VAddrSize, memory row.
- mem_wdata, out, 3, write data.
- mem_rdata, in, 3, synchronous read data, valid the cycle after a read.
- fifo_count, out, clog2(FifoDepth)+1, buffered entries.
- stall_count, out, 8, reads dropped by the starvation guard.

Function
REQ-003 SHALL drive mem_* combinationally from the current-cycle grant; the grant is single-port, at most one access per cycle.
REQ-004 SHALL grant priority as follows: (a) forced write (REQ-011); (b) else vga_rd_req gives a read at vga_addr_h/v; (c) else a non-empty FIFO gives a write of the head entry, which is popped; (d) else mem_en=0.
REQ-005 SHALL give read latency 2: request in cycle N; mem_rdata sampled at the end of N+1; vga_color updated and vga_color_valid high in N+2 only.
REQ-006 SHALL hold vga_color unchanged between updates.
REQ-007 SHALL set wr_ready = (fifo_count < FifoDepth), registered state only; when full, a same-cycle pop does not make wr_ready high in that cycle.
REQ-008 SHALL push on wr_valid && wr_ready; simultaneous push and pop leaves fifo_count unchanged.
REQ-009 SHALL have no empty-FIFO bypass: a pushed pixel is written no earlier than the cycle after the push.
REQ-010 SHALL issue writes in strict push order; no read-after-write coherence is provided.

Reset
REQ-012 SHALL, while reset is low, asynchronously clear the FIFO, fifo_count, wait counter, stall_count, vga_color (3'b000), vga_color_valid, wr_ready and all mem_* outputs to 0.
REQ-013 SHALL, on reset mid-operation, discard buffered writes and in-flight reads (no vga_color_valid pulse for them).
REQ-014 SHALL raise wr_ready in the first cycle after reset deasserts.

Configuration
REQ-011 SHALL implement the starvation guard when macro FRAME_BUFFER_ARBITER_STARVE_GUARD_EN is defined:
- the wait counter counts consecutive cycles with the FIFO non-empty and no pop, and clears on any pop;
- when the counter reaches MaxWait, the next cycle is a forced write even if vga_rd_req is high;
- that read is dropped: no vga_color_valid pulse, vga_color held;
- stall_count increments, saturating at 255.
REQ-015 SHALL, without the macro, give strict VGA priority; stall_count is tied to 0 and MaxWait is unused.

Verification
REQ-016 SHALL cover: reset low with wr_valid=1 -> wr_ready=0, mem_en=0, vga_color=000; release reset -> wr_ready=1 next cycle.
REQ-017 SHALL cover: vga_rd_req at (2,3) in cycle N, mem_rdata=3'b101 in N+1 -> vga_color=101 with valid pulse in N+2 only.
REQ-018 SHALL cover: 5 back-to-back pushes with vga_rd_req held high -> 4 accepted, wr_ready=0, fifo_count=4; drop vga_rd_req -> 4 writes in push order on consecutive cycles.
REQ-019 SHALL cover: FIFO full, push and pop in the same cycle -> push refused, fifo_count=3 next cycle.
REQ-020 SHALL cover, guard build with MaxWait=16: one buffered write and vga_rd_req held high -> write forced at cycle 17, that read gets no valid pulse, stall_count=1; non-guard build -> write waits until vga_rd_req drops.
REQ-021 SHALL cover: reset asserted with 3 entries buffered and a read in flight -> fifo_count=0, no valid pulse, no writes issued after release.
